// File: rtl/tdm_audio_top.sv
// TDM audio loopback: generates bclk/wclk from mclk_in, captures a full frame of
// serial slot data and retransmits it unchanged, slot for slot, one frame later.
module tdm_audio_top #(
    parameter int SLOTS     = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic mclk_in,
    input  logic rst_n,
    output logic bclk,
    output logic wclk,
    input  logic tdm_in,
    output logic tdm_out
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BIT_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    // The frame bit counter is held as a slot/bit pair so slot and bit index
    // come straight from the register with no divider.
    logic [SLOT_W-1:0]    slot_idx;
    logic [BIT_W-1:0]     bit_idx;
    logic [SLOT_W-1:0]    nxt_slot;
    logic [BIT_W-1:0]     nxt_bit;
    logic [BIT_W-1:0]     tx_bit_sel;
    logic                 last_bit;
    logic                 last_slot;
    logic                 frame_wrap;
    logic                 rise_evt;
    logic                 fall_evt;

    logic [SLOT_BITS-1:0] rx_shift;
    logic [SLOT_BITS-1:0] rx_word_next;
    logic [SLOT_BITS-1:0] rx_buf [SLOTS];
    logic [SLOT_BITS-1:0] tx_buf [SLOTS];

    // bclk is still low on the edge that raises it, high on the edge that drops it
    assign rise_evt     = ~bclk;
    assign fall_evt     = bclk;
    assign rx_word_next = {rx_shift[SLOT_BITS-2:0], tdm_in};

    // Next counter position and the transmit bit that goes with it
    always_comb begin
        last_bit   = (bit_idx == BIT_W'(SLOT_BITS - 1));
        last_slot  = (slot_idx == SLOT_W'(SLOTS - 1));
        frame_wrap = last_bit && last_slot;
        nxt_bit    = last_bit ? '0 : bit_idx + BIT_W'(1);
        nxt_slot   = slot_idx;
        if (last_bit) begin
            nxt_slot = last_slot ? '0 : slot_idx + SLOT_W'(1);
        end
        tx_bit_sel = BIT_W'(SLOT_BITS - 1) - nxt_bit;
    end

    // Bit clock: divide mclk_in by two
    always_ff @(posedge mclk_in or negedge rst_n) begin
        if (!rst_n) begin
            bclk <= 1'b0;
        end else begin
            bclk <= ~bclk;
        end
    end

    // Frame bit counter advances on each bclk falling event; resets to the last
    // position so the first falling event after reset starts frame 0
    always_ff @(posedge mclk_in or negedge rst_n) begin
        if (!rst_n) begin
            slot_idx <= SLOT_W'(SLOTS - 1);
            bit_idx  <= BIT_W'(SLOT_BITS - 1);
        end else if (fall_evt) begin
            slot_idx <= nxt_slot;
            bit_idx  <= nxt_bit;
        end
    end

    // Frame sync is high for the one bclk period in which the counter reads 0
    always_ff @(posedge mclk_in or negedge rst_n) begin
        if (!rst_n) begin
            wclk <= 1'b0;
        end else if (fall_evt) begin
            wclk <= frame_wrap;
        end
    end

    // Receive: shift in MSB first on rising events, park each finished word in its slot
    always_ff @(posedge mclk_in or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                rx_buf[i] <= '0;
            end
        end else if (rise_evt) begin
            rx_shift <= rx_word_next;
            if (last_bit) begin
                rx_buf[slot_idx] <= rx_word_next;
            end
        end
    end

    // Transmit: snapshot the received frame at the wrap and serialise it MSB first;
    // the first bit after the wrap is taken from rx_buf directly since tx_buf
    // is only being loaded on that same edge
    always_ff @(posedge mclk_in or negedge rst_n) begin
        if (!rst_n) begin
            tdm_out <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                tx_buf[i] <= '0;
            end
        end else if (fall_evt) begin
            if (frame_wrap) begin
                tx_buf  <= rx_buf;
                tdm_out <= rx_buf[0][SLOT_BITS-1];
            end else begin
                tdm_out <= tx_buf[nxt_slot][tx_bit_sel];
            end
        end
    end

endmodule

// File: tb/tb_tdm_audio_top.sv
// Testbench for tdm_audio_top: drives frames of slot data bit by bit, queues each
// driven bit as the value expected on tdm_out one frame later, and compares.
module tb_tdm_audio_top;

    logic mclk_in = 1'b0;
    logic rst_n   = 1'b0;
    logic tdm_in  = 1'b0;
    logic bclk;
    logic wclk;
    logic tdm_out;

    int checks     = 0;
    int errors     = 0;
    int edge_cnt   = 0;
    int drive_edge = -1;
    int obs_edge   = -1;

    logic        exp_q [$];
    logic [31:0] frame_words [8];

    tdm_audio_top #(.SLOTS(8), .SLOT_BITS(32)) dut (
        .mclk_in (mclk_in),
        .rst_n   (rst_n),
        .bclk    (bclk),
        .wclk    (wclk),
        .tdm_in  (tdm_in),
        .tdm_out (tdm_out)
    );

    // 80 ns master clock
    initial forever #40 mclk_in = ~mclk_in;

    // Count master clock rising edges for latency measurement
    always @(posedge mclk_in) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_zero_frame();
        repeat (256) exp_q.push_back(1'b0);
    endtask

    // Release reset at a low phase and check the first two edges
    task automatic release_reset();
        repeat (2) @(negedge mclk_in);
        check_output("reset bclk", {31'b0, bclk}, 32'd0);
        check_output("reset wclk", {31'b0, wclk}, 32'd0);
        check_output("reset tdm_out", {31'b0, tdm_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge mclk_in);
        check_output("first edge bclk", {31'b0, bclk}, 32'd1);
        check_output("first edge wclk", {31'b0, wclk}, 32'd0);
        @(negedge mclk_in);
    endtask

    // Run one frame from the low phase after its first falling event; stop early at stop_at
    task automatic apply_stimulus(input int frame_no, input int stop_at);
        logic d;
        logic e;
        for (int c = 0; c < 256; c++) begin
            if (c == stop_at) return;
            check_output($sformatf("bclk low f%0d c%0d", frame_no, c), {31'b0, bclk}, 32'd0);
            check_output($sformatf("wclk f%0d c%0d", frame_no, c), {31'b0, wclk}, (c == 0) ? 32'd1 : 32'd0);
            check_output($sformatf("scoreboard f%0d c%0d", frame_no, c), (exp_q.size() == 0) ? 32'd1 : 32'd0, 32'd0);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
            check_output($sformatf("tdm_out f%0d slot%0d bit%0d", frame_no, c / 32, c % 32), {31'b0, tdm_out}, {31'b0, e});
            if (frame_no == 4 && c == 160 && tdm_out === 1'b1) obs_edge = edge_cnt;
            d = frame_words[c / 32][31 - (c % 32)];
            tdm_in = d;
            exp_q.push_back(d);
            if (frame_no == 3 && c == 160 && d) drive_edge = edge_cnt;
            @(negedge mclk_in);
            check_output($sformatf("bclk high f%0d c%0d", frame_no, c), {31'b0, bclk}, 32'd1);
            check_output($sformatf("tdm_out hold f%0d c%0d", frame_no, c), {31'b0, tdm_out}, {31'b0, e});
            @(negedge mclk_in);
        end
    endtask

    initial begin
        $display("[TB] start");
        push_zero_frame();
        release_reset();

        // Known pattern
        for (int s = 0; s < 8; s++) frame_words[s] = 32'hA500_0000 + 32'(s);
        apply_stimulus(0, 256);

        // Frame boundary words plus random middle slots
        for (int s = 0; s < 8; s++) frame_words[s] = $urandom;
        frame_words[0] = 32'h0000_0001;
        frame_words[7] = 32'hFFFF_FFFF;
        apply_stimulus(1, 256);

        // Constant one
        for (int s = 0; s < 8; s++) frame_words[s] = 32'hFFFF_FFFF;
        apply_stimulus(2, 256);

        // Single one at slot 5 MSB
        for (int s = 0; s < 8; s++) frame_words[s] = 32'h0000_0000;
        frame_words[5] = 32'h8000_0000;
        apply_stimulus(3, 256);

        // All ones so the mid-frame reset has a high tdm_out to clear
        for (int s = 0; s < 8; s++) frame_words[s] = 32'hFFFF_FFFF;
        apply_stimulus(4, 256);
        check_output("latency mclk", 32'(obs_edge - drive_edge), 32'd512);

        // Mid-frame reset at counter 100
        for (int s = 0; s < 8; s++) frame_words[s] = $urandom;
        apply_stimulus(5, 100);
        check_output("pre-reset tdm_out", {31'b0, tdm_out}, 32'd1);
        rst_n  = 1'b0;
        tdm_in = 1'b0;
        #1;
        check_output("mid reset bclk", {31'b0, bclk}, 32'd0);
        check_output("mid reset wclk", {31'b0, wclk}, 32'd0);
        check_output("mid reset tdm_out", {31'b0, tdm_out}, 32'd0);
        exp_q.delete();
        push_zero_frame();
        release_reset();

        for (int s = 0; s < 8; s++) frame_words[s] = $urandom;
        apply_stimulus(6, 256);
        for (int s = 0; s < 8; s++) frame_words[s] = $urandom;
        apply_stimulus(7, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
